// File: rtl/divu128by64_seq_if.sv
// Handshake and operand/result bundle for the sequential unsigned divider.
// The master drives the operands and the start pulse. The slave returns the results and flags.
interface divu128by64_seq_if #(
    parameter int unsigned WID = 64
);
    logic               ce;
    logic               ld;
    logic [2*WID-1:0]   a;
    logic [WID-1:0]     b;
    logic [WID-1:0]     q;
    logic [WID-1:0]     r;
    logic               busy;
    logic               done;
    logic               dbz;
    logic               ovf;

    modport master (
        output ce, ld, a, b,
        input  q, r, busy, done, dbz, ovf
    );

    modport slave (
        input  ce, ld, a, b,
        output q, r, busy, done, dbz, ovf
    );
endinterface

// File: rtl/divu128by64_seq.sv
// Radix-2 restoring unsigned divider: 2*WID-bit dividend / WID-bit divisor.
// It produces one quotient bit per enabled cycle, and a new ld restarts the divider from any state.
module divu128by64_seq #(
    parameter int unsigned WID = 64
) (
    input logic               clk,
    input logic               rst,
    divu128by64_seq_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WID + 1);

    typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

    state_e          state_q, state_d;
    logic [WID-1:0]  ph_q, ph_d;
    logic [WID-1:0]  pl_q, pl_d;
    logic [WID-1:0]  b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WID-1:0]  q_q, q_d;
    logic [WID-1:0]  r_q, r_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    // Partial remainder is kept one bit wider so the shifted-out MSB is never lost.
    logic [WID:0]    t;
    logic [WID:0]    diff;
    logic            qbit;
    logic [WID-1:0]  ph_nxt;
    logic [WID-1:0]  pl_nxt;

    always_comb begin
        t      = {ph_q, pl_q[WID-1]};
        diff   = t - {1'b0, b_q};
        qbit   = (t >= {1'b0, b_q});
        ph_nxt = qbit ? diff[WID-1:0] : t[WID-1:0];
        pl_nxt = {pl_q[WID-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        if (bus.ld) begin
            done_d = 1'b0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
            if (bus.b == '0) begin
                state_d = StDone;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
                q_d     = '1;
                r_d     = bus.a[WID-1:0];
            end else if (bus.a[2*WID-1:WID] >= bus.b) begin
                state_d = StDone;
                done_d  = 1'b1;
                ovf_d   = 1'b1;
                q_d     = '1;
                r_d     = '0;
            end else begin
                state_d = StDivide;
                ph_d    = bus.a[2*WID-1:WID];
                pl_d    = bus.a[WID-1:0];
                b_d     = bus.b;
                cnt_d   = CntW'(WID);
            end
        end else if (state_q == StDivide) begin
            ph_d  = ph_nxt;
            pl_d  = pl_nxt;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                state_d = StDone;
                q_d     = pl_nxt;
                r_d     = ph_nxt;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ph_q    <= '0;
            pl_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.ce) begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = (state_q == StDivide);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_divu128by64_seq.sv
// Directed bench for divu128by64_seq: latency, flags, clock enable, restart, reset and random vectors.
module tb_divu128by64_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   edges;
    int   busy_n;
    logic [127:0] ra;
    logic [63:0]  rb;
    logic [127:0] eq;
    logic [127:0] er;

    divu128by64_seq_if #(.WID(64)) bus ();

    divu128by64_seq #(.WID(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input logic [127:0] av, input logic [63:0] bv);
        bus.a  = av;
        bus.b  = bv;
        bus.ld = 1'b1;
        tick();
        bus.ld = 1'b0;
    endtask

    // Counts edges from the ld edge (inclusive) until done, bounded.
    task automatic wait_done(output int e, output int bn);
        e  = 1;
        bn = int'(bus.busy);
        while (!bus.done && e < 300) begin
            tick();
            e  = e + 1;
            bn = bn + int'(bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.ce   = 1'b1;
        bus.ld   = 1'b0;
        bus.a    = '0;
        bus.b    = '0;
        tick();
        chk("rst_q", 128'(bus.q), 128'd0);
        chk("rst_r", 128'(bus.r), 128'd0);
        chk("rst_flags", 128'({bus.busy, bus.done, bus.dbz, bus.ovf}), 128'd0);
        rst = 1'b0;
        tick();

        // 100 / 7
        start(128'd100, 64'd7);
        wait_done(edges, busy_n);
        chk("t1_latency", 128'(edges), 128'd65);
        chk("t1_busy_cycles", 128'(busy_n), 128'd64);
        chk("t1_q", 128'(bus.q), 128'd14);
        chk("t1_r", 128'(bus.r), 128'd2);
        chk("t1_flags", 128'({bus.busy, bus.dbz, bus.ovf}), 128'd0);
        tick();
        tick();
        chk("t1_done_hold", 128'({bus.done, bus.q}), {63'd0, 1'b1, 64'd14});

        // ld must be ignored while ce is low
        bus.ce = 1'b0;
        start(128'd50, 64'd6);
        chk("ce_ld_ignored", 128'({bus.busy, bus.done, bus.q}), {62'd0, 2'b01, 64'd14});
        bus.ce = 1'b1;

        // Largest non-overflowing quotient
        start(128'hFFFF_FFFF_FFFF_FFFE_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(edges, busy_n);
        chk("t2_q", 128'(bus.q), 128'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_r", 128'(bus.r), 128'hFFFF_FFFF_FFFF_FFFE);

        // Divide by zero and overflow resolve in one edge
        start(128'd123, 64'd0);
        chk("dbz_done", 128'({bus.busy, bus.done, bus.dbz, bus.ovf}), 128'b0110);
        chk("dbz_q", 128'(bus.q), 128'hFFFF_FFFF_FFFF_FFFF);
        chk("dbz_r", 128'(bus.r), 128'd123);
        start({64'd5, 64'd0}, 64'd5);
        chk("ovf_done", 128'({bus.busy, bus.done, bus.dbz, bus.ovf}), 128'b0101);
        chk("ovf_q", 128'(bus.q), 128'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_r", 128'(bus.r), 128'd0);

        // Clock enable low for 10 cycles mid-divide
        start(128'd1000, 64'd3);
        edges = 1;
        repeat (20) begin
            tick();
            edges = edges + 1;
        end
        bus.ce = 1'b0;
        repeat (10) begin
            tick();
            edges = edges + 1;
        end
        chk("ce_hold", 128'({bus.busy, bus.done}), 128'b10);
        bus.ce = 1'b1;
        while (!bus.done && edges < 300) begin
            tick();
            edges = edges + 1;
        end
        chk("t4_latency", 128'(edges), 128'd75);
        chk("t4_q", 128'(bus.q), 128'd333);
        chk("t4_r", 128'(bus.r), 128'd1);

        // Restart at iteration 30
        start(128'd1000, 64'd3);
        repeat (30) tick();
        start(128'd50, 64'd6);
        wait_done(edges, busy_n);
        chk("t5_latency", 128'(edges), 128'd65);
        chk("t5_q", 128'(bus.q), 128'd8);
        chk("t5_r", 128'(bus.r), 128'd2);

        // ld on the final iteration edge wins
        start(128'd1000, 64'd3);
        repeat (63) tick();
        start(128'd9, 64'd3);
        chk("ld_last_edge", 128'({bus.busy, bus.done}), 128'b10);
        wait_done(edges, busy_n);
        chk("ld_last_latency", 128'(edges), 128'd65);
        chk("ld_last_q", 128'(bus.q), 128'd3);

        // Asynchronous reset mid-divide
        start(128'd1000, 64'd3);
        repeat (40) tick();
        rst = 1'b1;
        #1;
        chk("arst_q", 128'(bus.q), 128'd0);
        chk("arst_flags", 128'({bus.busy, bus.done, bus.dbz, bus.ovf}), 128'd0);
        #1;
        rst = 1'b0;
        start(128'd9, 64'd3);
        wait_done(edges, busy_n);
        chk("t6_q", 128'(bus.q), 128'd3);
        chk("t6_r", 128'(bus.r), 128'd0);

        // Random non-overflowing operands against a native 128-bit model
        for (int i = 0; i < 4; i++) begin
            rb = {$urandom, $urandom} | 64'd1;
            ra = {({$urandom, $urandom} % rb), $urandom, $urandom};
            eq = ra / {64'd0, rb};
            er = ra % {64'd0, rb};
            start(ra, rb);
            wait_done(edges, busy_n);
            chk("rand_latency", 128'(edges), 128'd65);
            chk("rand_q", 128'(bus.q), eq);
            chk("rand_r", 128'(bus.r), er);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
